// File: rtl/condicionador_botoes.sv
// condicionador_botoes
// Conditions the four raw game push-buttons for the memory-game datapath.
// The raw buttons go through a two-flop synchroniser and then a debounce FSM.
// Each accepted press produces one registered pulse:
//   - jogada_feita when exactly one button is pressed, which also updates the
//     one-hot play register;
//   - erro_multiplo when several buttons are pressed together.
// The FSM stays latched in PRESSIONADO until the release has been debounced,
// so a button that is held down can never be accepted twice.
module condicionador_botoes #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int CW              = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    input  logic       limpa,
    output logic [3:0] jogada,
    output logic [1:0] codigo,
    output logic       jogada_feita,
    output logic       erro_multiplo,
    output logic       botao_ativo,
    output logic [3:0] db_estado
);

    typedef enum logic [1:0] {
        ESPERA       = 2'd0,
        FILTRA_PRESS = 2'd1,
        PRESSIONADO  = 2'd2,
        FILTRA_SOLTA = 2'd3
    } estado_t;

    // Terminal count. A value has to match on this many consecutive
    // filter cycles before the FSM leaves a FILTRA state.
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [3:0]    botoesSinc;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    jogada_q, jogada_d;
    logic          feita_q, feita_d;
    logic          erro_q, erro_d;
    logic          candUnico;

    // Two-flop synchroniser. The raw buttons are asynchronous to clock, and
    // the FSM only ever looks at the second stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= botoes;
            sync2_q <= sync1_q;
        end
    end

    assign botoesSinc = sync2_q;

    // Only a candidate with exactly one button set counts as a valid play.
    assign candUnico = (cand_q == 4'b0001) || (cand_q == 4'b0010) ||
                       (cand_q == 4'b0100) || (cand_q == 4'b1000);

    // Next-state logic for the debounce FSM, its counter, the candidate and
    // the registered outputs. The pulses default to zero, so each one lasts
    // a single cycle. A clear from limpa is written first, which lets an
    // accept happening in the same cycle override it.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        jogada_d = jogada_q;
        feita_d  = 1'b0;
        erro_d   = 1'b0;

        if (limpa) begin
            jogada_d = 4'b0000;
        end

        case (estado_q)
            ESPERA: begin
                if (botoesSinc != 4'b0000) begin
                    cand_d   = botoesSinc;
                    cnt_d    = '0;
                    estado_d = FILTRA_PRESS;
                end
            end

            FILTRA_PRESS: begin
                if (botoesSinc != cand_q) begin
                    estado_d = ESPERA;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = PRESSIONADO;
                    if (habilita) begin
                        if (candUnico) begin
                            jogada_d = cand_q;
                            feita_d  = 1'b1;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            PRESSIONADO: begin
                if (botoesSinc == 4'b0000) begin
                    cnt_d    = '0;
                    estado_d = FILTRA_SOLTA;
                end
            end

            FILTRA_SOLTA: begin
                if (botoesSinc != 4'b0000) begin
                    estado_d = PRESSIONADO;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = ESPERA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                estado_d = ESPERA;
            end
        endcase
    end

    // State, counter, candidate and output registers. All of them are
    // cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= ESPERA;
            cnt_q    <= '0;
            cand_q   <= 4'b0000;
            jogada_q <= 4'b0000;
            feita_q  <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            jogada_q <= jogada_d;
            feita_q  <= feita_d;
            erro_q   <= erro_d;
        end
    end

    // Encode the registered one-hot play into its 2-bit code. Because the
    // code depends only on jogada_q, it changes in step with jogada.
    always_comb begin
        codigo = 2'd0;
        case (jogada_q)
            4'b0001: codigo = 2'd0;
            4'b0010: codigo = 2'd1;
            4'b0100: codigo = 2'd2;
            4'b1000: codigo = 2'd3;
            default: codigo = 2'd0;
        endcase
    end

    assign jogada        = jogada_q;
    assign jogada_feita  = feita_q;
    assign erro_multiplo = erro_q;
    assign botao_ativo   = (estado_q == PRESSIONADO) || (estado_q == FILTRA_SOLTA);
    assign db_estado     = {2'b00, estado_q};

endmodule

// File: tb/tb_condicionador_botoes.sv
// Testbench for condicionador_botoes, built with a short debounce window.
// The reference model follows the button-conditioning rules directly:
//   - a press is accepted after DEB+1 consecutive identical non-zero samples
//     seen while idle;
//   - a release is complete after DEB+1 consecutive zero samples seen while
//     held.
module tb_condicionador_botoes;

    localparam int DEB = 4;
    localparam int CW  = 4;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic [3:0] botoes   = 4'b0000;
    logic       habilita = 1'b1;
    logic       limpa    = 1'b0;

    logic [3:0] jogada;
    logic [1:0] codigo;
    logic       jogada_feita;
    logic       erro_multiplo;
    logic       botao_ativo;
    logic [3:0] db_estado;
    logic [12:0] obsVec;

    int errors = 0;
    int checks = 0;

    condicionador_botoes #(.DEBOUNCE_CICLOS(DEB), .CW(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes       (botoes),
        .habilita     (habilita),
        .limpa        (limpa),
        .jogada       (jogada),
        .codigo       (codigo),
        .jogada_feita (jogada_feita),
        .erro_multiplo(erro_multiplo),
        .botao_ativo  (botao_ativo),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    assign obsVec = {jogada, codigo, jogada_feita, erro_multiplo, botao_ativo, db_estado};

    // Reference model state.
    //   mHeld:  a press has been accepted and its release is not yet debounced
    //   mCount: consecutive samples matching the candidate (0 = idle)
    //   mQuiet: consecutive zero samples seen while held
    logic [3:0] ms1 = 4'b0000, ms2 = 4'b0000, mCand = 4'b0000, mJog = 4'b0000;
    logic       mFeita = 1'b0, mErro = 1'b0;
    bit         mHeld = 1'b0;
    int         mCount = 0, mQuiet = 0;

    function automatic logic [1:0] encode(input logic [3:0] v);
        case (v)
            4'b0001: return 2'd0;
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Expected output vector, in the same bit order as obsVec.
    function automatic logic [12:0] expVec();
        logic [3:0] est;
        if (!mHeld) est = (mCount == 0) ? 4'd0 : 4'd1;
        else        est = (mQuiet == 0) ? 4'd2 : 4'd3;
        return {mJog, encode(mJog), mFeita, mErro, mHeld ? 1'b1 : 1'b0, est};
    endfunction

    // Model update. Inputs only change just after a negedge, so they are
    // stable at every posedge. The model resets asynchronously, like the DUT.
    always @(posedge clock or negedge reset) begin
        logic [3:0] s;
        if (!reset) begin
            ms1 = 4'b0000; ms2 = 4'b0000; mCand = 4'b0000; mJog = 4'b0000;
            mFeita = 1'b0; mErro = 1'b0; mHeld = 1'b0; mCount = 0; mQuiet = 0;
        end else begin
            s = ms2;
            ms2 = ms1;
            ms1 = botoes;
            mFeita = 1'b0;
            mErro = 1'b0;
            if (limpa) mJog = 4'b0000;
            if (!mHeld) begin
                if (mCount == 0) begin
                    if (s != 4'b0000) begin
                        mCand = s;
                        mCount = 1;
                    end
                end else if (s == mCand) begin
                    mCount++;
                    if (mCount == DEB + 1) begin
                        mHeld = 1'b1;
                        mCount = 0;
                        mQuiet = 0;
                        if (habilita) begin
                            if ($countones(mCand) == 1) begin
                                mJog = mCand;
                                mFeita = 1'b1;
                            end else begin
                                mErro = 1'b1;
                            end
                        end
                    end
                end else begin
                    mCount = 0;
                end
            end else begin
                if (s != 4'b0000) begin
                    mQuiet = 0;
                end else begin
                    mQuiet++;
                    if (mQuiet == DEB + 1) begin
                        mHeld = 1'b0;
                        mQuiet = 0;
                    end
                end
            end
        end
    end

    // Reset held with buttons pressed: every output must stay at zero.
    task automatic test_reset();
        reset = 1'b0;
        botoes = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== 13'h0000) begin
                errors++;
                $display("[TB] FAIL reset_outputs cyc%0d: got %h want 0000", i, obsVec);
            end
        end
        reset = 1'b1;
        botoes = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL reset_idle cyc%0d: got %h want %h", i, obsVec, expVec());
            end
        end
    endtask

    // A clean single press: one pulse, seven cycles after the first sampling edge.
    task automatic test_clean_press();
        int pulses = 0;
        int firstIdx = 0;
        botoes = 4'b0010;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL clean_press cyc%0d: got %h want %h", i, obsVec, expVec());
            end
            if (jogada_feita) begin
                pulses++;
                if (firstIdx == 0) firstIdx = i;
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("[TB] FAIL clean_press_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (firstIdx !== 7) begin
            errors++;
            $display("[TB] FAIL clean_press_latency: got %0d want 7", firstIdx);
        end
        checks++;
        if ({jogada, codigo, botao_ativo} !== {4'b0010, 2'd1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL clean_press_final: got %b %0d %b want 0010 1 1", jogada, codigo, botao_ativo);
        end
        botoes = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL clean_release cyc%0d: got %h want %h", i, obsVec, expVec());
            end
        end
    endtask

    // Press bounce: 2-cycle toggling must be rejected, and the steady hold accepted once.
    task automatic test_press_bounce();
        int pulsesToggle = 0;
        int pulsesHold = 0;
        for (int i = 0; i < 12; i++) begin
            botoes = ((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL press_bounce_toggle cyc%0d: got %h want %h", i, obsVec, expVec());
            end
            if (jogada_feita) pulsesToggle++;
        end
        botoes = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL press_bounce_hold cyc%0d: got %h want %h", i, obsVec, expVec());
            end
            if (jogada_feita) pulsesHold++;
        end
        checks++;
        if (pulsesToggle !== 0 || pulsesHold !== 1 || jogada !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL press_bounce_summary: got %0d/%0d jogada=%b want 0/1 jogada=0100", pulsesToggle, pulsesHold, jogada);
        end
        botoes = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL press_bounce_release cyc%0d: got %h want %h", i, obsVec, expVec());
            end
        end
    endtask

    // Two buttons pressed together: one error pulse, no play pulse, jogada unchanged.
    task automatic test_multi();
        int erros = 0;
        int feitas = 0;
        botoes = 4'b1001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL multi cyc%0d: got %h want %h", i, obsVec, expVec());
            end
            if (erro_multiplo) erros++;
            if (jogada_feita) feitas++;
        end
        checks++;
        if (erros !== 1 || feitas !== 0 || jogada !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL multi_summary: got erro=%0d feita=%0d jogada=%b want 1 0 0100", erros, feitas, jogada);
        end
        botoes = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL multi_release cyc%0d: got %h want %h", i, obsVec, expVec());
            end
        end
    endtask

    // Press accepted while disabled: enabling mid-hold must not produce a late pulse.
    task automatic test_habilita();
        logic [3:0] vals [4] = '{4'b1000, 4'b1000, 4'b0000, 4'b1000};
        logic       habs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int         lens [4] = '{12, 10, 10, 12};
        int         pulses [4] = '{0, 0, 0, 0};
        for (int sg = 0; sg < 4; sg++) begin
            botoes = vals[sg];
            habilita = habs[sg];
            for (int i = 0; i < lens[sg]; i++) begin
                @(negedge clock);
                checks++;
                if (obsVec !== expVec()) begin
                    errors++;
                    $display("[TB] FAIL habilita seg%0d cyc%0d: got %h want %h", sg, i, obsVec, expVec());
                end
                if (jogada_feita || erro_multiplo) pulses[sg]++;
            end
            if (sg == 2) begin
                checks++;
                if (db_estado !== 4'd0) begin
                    errors++;
                    $display("[TB] FAIL habilita_idle_state: got %0d want 0", db_estado);
                end
            end
        end
        checks++;
        if (pulses[0] + pulses[1] + pulses[2] !== 0 || pulses[3] !== 1 || jogada !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL habilita_summary: got %0d/%0d/%0d/%0d jogada=%b want 0/0/0/1 1000", pulses[0], pulses[1], pulses[2], pulses[3], jogada);
        end
        botoes = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL habilita_release cyc%0d: got %h want %h", i, obsVec, expVec());
            end
        end
    endtask

    // Release bounce: alternating zero/one-cycle presses after acceptance give no second pulse.
    task automatic test_release_bounce();
        int pulses = 0;
        for (int i = 0; i < 26; i++) begin
            if (i < 10)      botoes = 4'b0001;
            else if (i < 16) botoes = (i % 2 == 0) ? 4'b0000 : 4'b0001;
            else             botoes = 4'b0000;
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL release_bounce cyc%0d: got %h want %h", i, obsVec, expVec());
            end
            if (jogada_feita) pulses++;
        end
        checks++;
        if (pulses !== 1 || db_estado !== 4'd0 || jogada !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL release_bounce_summary: got pulses=%0d estado=%0d jogada=%b want 1 0 0001", pulses, db_estado, jogada);
        end
    endtask

    // Asynchronous reset mid-filter and mid-hold, followed by a limpa clear.
    task automatic test_async_reset();
        int pulses = 0;
        botoes = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL async_pre cyc%0d: got %h want %h", i, obsVec, expVec());
            end
        end
        checks++;
        if (db_estado !== 4'd1) begin
            errors++;
            $display("[TB] FAIL async_filtering_state: got %0d want 1", db_estado);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obsVec !== 13'h0000) begin
            errors++;
            $display("[TB] FAIL async_reset_filtra: got %h want 0000", obsVec);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL async_refilter cyc%0d: got %h want %h", i, obsVec, expVec());
            end
            if (jogada_feita) pulses++;
        end
        checks++;
        if (pulses !== 1 || db_estado !== 4'd2 || jogada !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL async_refilter_summary: got %0d estado=%0d jogada=%b want 1 2 0010", pulses, db_estado, jogada);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obsVec !== 13'h0000) begin
            errors++;
            $display("[TB] FAIL async_reset_pressionado: got %h want 0000", obsVec);
        end
        @(negedge clock);
        reset = 1'b1;
        botoes = 4'b0000;
        for (int i = 0; i < 22; i++) begin
            botoes = (i < 12) ? 4'b1000 : 4'b0000;
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL async_press cyc%0d: got %h want %h", i, obsVec, expVec());
            end
        end
        limpa = 1'b1;
        @(negedge clock);
        checks++;
        if ({jogada, codigo} !== 6'b0000_00 || obsVec !== expVec()) begin
            errors++;
            $display("[TB] FAIL limpa_clear: got %b %0d want 0000 0", jogada, codigo);
        end
        limpa = 1'b0;
    endtask

    // limpa held across an accept: the accept wins for that one cycle.
    task automatic test_limpa_accept();
        int pulses = 0;
        limpa = 1'b1;
        botoes = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL limpa_accept cyc%0d: got %h want %h", i, obsVec, expVec());
            end
            if (jogada_feita) begin
                pulses++;
                checks++;
                if (jogada !== 4'b0001) begin
                    errors++;
                    $display("[TB] FAIL limpa_accept_wins: got %b want 0001", jogada);
                end
            end
        end
        checks++;
        if (pulses !== 1 || jogada !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL limpa_accept_summary: got %0d jogada=%b want 1 0000", pulses, jogada);
        end
        limpa = 1'b0;
        botoes = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (obsVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL limpa_release cyc%0d: got %h want %h", i, obsVec, expVec());
            end
        end
    endtask

    // Random segments of buttons, enable and clear, checked against the model.
    task automatic test_random();
        for (int sg = 0; sg < 60; sg++) begin
            int len;
            case ($urandom_range(0, 3))
                0:       botoes = 4'($urandom_range(0, 15));
                1:       botoes = 4'b0000;
                default: botoes = 4'(1 << $urandom_range(0, 3));
            endcase
            habilita = ($urandom_range(0, 4) != 0);
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                limpa = ($urandom_range(0, 9) == 0);
                @(negedge clock);
                checks++;
                if (obsVec !== expVec()) begin
                    errors++;
                    $display("[TB] FAIL random seg%0d cyc%0d: got %h want %h", sg, i, obsVec, expVec());
                end
                if (jogada_feita && erro_multiplo) begin
                    errors++;
                    $display("[TB] FAIL random_both_pulses seg%0d: got 1/1 want exclusive", sg);
                end
            end
        end
        limpa = 1'b0;
        habilita = 1'b1;
        botoes = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_multi();
        test_habilita();
        test_release_bounce();
        test_async_reset();
        test_limpa_accept();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
